// File: rtl/ysyx_22050019_axi_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter: grant states, response
// codes and the fixed-priority pick used when leaving IDLE.
package ysyx_22050019_axi_arbiter_pkg;

  typedef logic [2:0] arb_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_IF_AR = 3'd1;
  localparam logic [2:0] ST_IF_R  = 3'd2;
  localparam logic [2:0] ST_LS_AR = 3'd3;
  localparam logic [2:0] ST_LS_R  = 3'd4;
  localparam logic [2:0] ST_LS_WR = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // LSU write beats LSU read beats IFU fetch
  function automatic arb_state_t arb_pick(input logic lsu_aw, input logic lsu_ar,
                                          input logic ifu_ar);
    if (lsu_aw)      return ST_LS_WR;
    else if (lsu_ar) return ST_LS_AR;
    else if (ifu_ar) return ST_IF_AR;
    else             return ST_IDLE;
  endfunction

endpackage

// File: rtl/ysyx_22050019_axi_arbiter_if.sv
// AXI4-lite-style five-channel bundle; master drives requests, slave answers.
interface ysyx_22050019_axi_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/ysyx_22050019_arb_fsm.sv
// Grant state register for the memory-port arbiter plus the AW/W completion
// flags that gate B forwarding during a write.
module ysyx_22050019_arb_fsm
  import ysyx_22050019_axi_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ifu_ar_valid,
  input  logic       lsu_ar_valid,
  input  logic       lsu_aw_valid,
  input  logic       ar_hs,
  input  logic       r_hs,
  input  logic       aw_hs,
  input  logic       w_hs,
  input  logic       b_hs,
  output arb_state_t state,
  output logic       aw_done,
  output logic       w_done
);

  arb_state_t state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = arb_pick(lsu_aw_valid, lsu_ar_valid, ifu_ar_valid);
      ST_IF_AR: if (ar_hs) state_nx = ST_IF_R;
      ST_IF_R:  if (r_hs)  state_nx = ST_IDLE;
      ST_LS_AR: if (ar_hs) state_nx = ST_LS_R;
      ST_LS_R:  if (r_hs)  state_nx = ST_IDLE;
      ST_LS_WR: if (b_hs)  state_nx = ST_IDLE;
      default:             state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      // B only completes once both flags are set, so leaving LS_WR clears them
      if (state == ST_LS_WR && b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22050019_axi_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write); single
// outstanding transaction, all forwarding combinational from the registered grant.
module ysyx_22050019_axi_arbiter
  import ysyx_22050019_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic rst,
  ysyx_22050019_axi_arbiter_if.slave  ifu,
  ysyx_22050019_axi_arbiter_if.slave  lsu,
  ysyx_22050019_axi_arbiter_if.master slv
);

  arb_state_t        state;
  logic              aw_done;
  logic              w_done;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0] ar_addr_sel;
  logic [DATA_W-1:0] r_data_fwd;
  logic              unused_ifu;

  assign ar_hs = slv.ar_valid & slv.ar_ready;
  assign r_hs  = slv.r_valid  & slv.r_ready;
  assign aw_hs = slv.aw_valid & slv.aw_ready;
  assign w_hs  = slv.w_valid  & slv.w_ready;
  assign b_hs  = slv.b_valid  & slv.b_ready;

  // The IFU never writes; its write-side request signals are ignored
  assign unused_ifu = ^{ifu.aw_valid, ifu.aw_addr, ifu.w_valid, ifu.w_data,
                        ifu.w_strb, ifu.b_ready};

  ysyx_22050019_arb_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .ifu_ar_valid (ifu.ar_valid),
    .lsu_ar_valid (lsu.ar_valid),
    .lsu_aw_valid (lsu.aw_valid),
    .ar_hs        (ar_hs),
    .r_hs         (r_hs),
    .aw_hs        (aw_hs),
    .w_hs         (w_hs),
    .b_hs         (b_hs),
    .state        (state),
    .aw_done      (aw_done),
    .w_done       (w_done)
  );

  assign slv.ar_addr = ar_addr_sel;
  assign r_data_fwd  = slv.r_data;

  always_comb begin
    ifu.ar_ready = 1'b0;
    ifu.r_valid  = 1'b0;
    ifu.r_data   = '0;
    ifu.r_resp   = RESP_OKAY;
    ifu.aw_ready = 1'b0;
    ifu.w_ready  = 1'b0;
    ifu.b_valid  = 1'b0;
    ifu.b_resp   = RESP_OKAY;
    lsu.ar_ready = 1'b0;
    lsu.r_valid  = 1'b0;
    lsu.r_data   = '0;
    lsu.r_resp   = RESP_OKAY;
    lsu.aw_ready = 1'b0;
    lsu.w_ready  = 1'b0;
    lsu.b_valid  = 1'b0;
    lsu.b_resp   = RESP_OKAY;
    slv.ar_valid = 1'b0;
    ar_addr_sel  = '0;
    slv.r_ready  = 1'b0;
    slv.aw_valid = 1'b0;
    slv.aw_addr  = '0;
    slv.w_valid  = 1'b0;
    slv.w_data   = '0;
    slv.w_strb   = '0;
    slv.b_ready  = 1'b0;
    case (state)
      ST_IF_AR: begin
        slv.ar_valid = ifu.ar_valid;
        ar_addr_sel  = ifu.ar_addr;
        ifu.ar_ready = slv.ar_ready;
      end
      ST_IF_R: begin
        ifu.r_valid = slv.r_valid;
        ifu.r_data  = r_data_fwd;
        ifu.r_resp  = slv.r_resp;
        slv.r_ready = ifu.r_ready;
      end
      ST_LS_AR: begin
        slv.ar_valid = lsu.ar_valid;
        ar_addr_sel  = lsu.ar_addr;
        lsu.ar_ready = slv.ar_ready;
      end
      ST_LS_R: begin
        lsu.r_valid = slv.r_valid;
        lsu.r_data  = r_data_fwd;
        lsu.r_resp  = slv.r_resp;
        slv.r_ready = lsu.r_ready;
      end
      ST_LS_WR: begin
        // each request channel goes quiet once its beat has been accepted
        if (!aw_done) begin
          slv.aw_valid = lsu.aw_valid;
          slv.aw_addr  = lsu.aw_addr;
          lsu.aw_ready = slv.aw_ready;
        end
        if (!w_done) begin
          slv.w_valid = lsu.w_valid;
          slv.w_data  = lsu.w_data;
          slv.w_strb  = lsu.w_strb;
          lsu.w_ready = slv.w_ready;
        end
        if (aw_done && w_done) begin
          lsu.b_valid = slv.b_valid;
          lsu.b_resp  = slv.b_resp;
          slv.b_ready = lsu.b_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
// Directed bench for the IFU/LSU memory-port arbiter: inputs change and outputs
// are observed just after the falling edge; grant state advances on the rising edge.
module tb_ysyx_22050019_axi_arbiter;
  import ysyx_22050019_axi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   wr_cnt = 0;
  int   b_cnt  = 0;

  always #5 clk = ~clk;

  ysyx_22050019_axi_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifu_bus ();
  ysyx_22050019_axi_arbiter_if #(.ADDR_W(64), .DATA_W(64)) lsu_bus ();
  ysyx_22050019_axi_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mem_bus ();

  ysyx_22050019_axi_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .slv (mem_bus)
  );

  always @(posedge clk) begin
    if (mem_bus.w_valid && mem_bus.w_ready) wr_cnt <= wr_cnt + 1;
    if (lsu_bus.b_valid && lsu_bus.b_ready) b_cnt <= b_cnt + 1;
  end

  function automatic logic [11:0] vr_outs();
    return {ifu_bus.ar_ready, ifu_bus.r_valid, lsu_bus.ar_ready, lsu_bus.r_valid,
            lsu_bus.aw_ready, lsu_bus.w_ready, lsu_bus.b_valid, mem_bus.ar_valid,
            mem_bus.r_ready, mem_bus.aw_valid, mem_bus.w_valid, mem_bus.b_ready};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_bus.ar_valid = 0; ifu_bus.ar_addr = '0; ifu_bus.r_ready = 0;
    ifu_bus.aw_valid = 0; ifu_bus.aw_addr = '0; ifu_bus.w_valid = 0;
    ifu_bus.w_data = '0; ifu_bus.w_strb = '0; ifu_bus.b_ready = 0;
    lsu_bus.ar_valid = 0; lsu_bus.ar_addr = '0; lsu_bus.r_ready = 0;
    lsu_bus.aw_valid = 0; lsu_bus.aw_addr = '0; lsu_bus.w_valid = 0;
    lsu_bus.w_data = '0; lsu_bus.w_strb = '0; lsu_bus.b_ready = 0;
    mem_bus.ar_ready = 0; mem_bus.r_valid = 0; mem_bus.r_data = '0; mem_bus.r_resp = 2'b00;
    mem_bus.aw_ready = 0; mem_bus.w_ready = 0; mem_bus.b_valid = 0; mem_bus.b_resp = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step(); lsu_bus.ar_valid = 1; mem_bus.ar_ready = 1; #1;
    step(); #1;
    total++; if (vr_outs() !== 12'h000) $display("FAIL reset_outs: got %h want %h", vr_outs(), 12'h000); else passed++;
    step(); rst = 1'b0; clear_inputs(); #1;
    total++; if (vr_outs() !== 12'h000) $display("FAIL reset_release_outs: got %h want %h", vr_outs(), 12'h000); else passed++;
  endtask

  task automatic test_ifu_read();
    step(); ifu_bus.ar_valid = 1; ifu_bus.ar_addr = 64'h8000_0000; mem_bus.ar_ready = 1; #1;
    total++; if (ifu_bus.ar_ready !== 1'b0) $display("FAIL t1_idle_ar_ready: got %h want %h", ifu_bus.ar_ready, 1'b0); else passed++;
    total++; if (mem_bus.ar_valid !== 1'b0) $display("FAIL t1_idle_s_ar_valid: got %h want %h", mem_bus.ar_valid, 1'b0); else passed++;
    step(); #1;
    total++; if (mem_bus.ar_valid !== 1'b1) $display("FAIL t1_s_ar_valid: got %h want %h", mem_bus.ar_valid, 1'b1); else passed++;
    total++; if (mem_bus.ar_addr !== 64'h8000_0000) $display("FAIL t1_s_ar_addr: got %h want %h", mem_bus.ar_addr, 64'h8000_0000); else passed++;
    total++; if (ifu_bus.ar_ready !== 1'b1) $display("FAIL t1_ar_ready: got %h want %h", ifu_bus.ar_ready, 1'b1); else passed++;
    step(); ifu_bus.ar_valid = 0; ifu_bus.ar_addr = '0; mem_bus.ar_ready = 0; ifu_bus.r_ready = 1; #1;
    total++; if ({ifu_bus.r_valid, mem_bus.r_ready} !== 2'b01) $display("FAIL t1_wait_r: got %b want %b", {ifu_bus.r_valid, mem_bus.r_ready}, 2'b01); else passed++;
    step(); #1;
    step(); mem_bus.r_valid = 1; mem_bus.r_data = 64'h1234; #1;
    total++; if (ifu_bus.r_valid !== 1'b1) $display("FAIL t1_r_valid: got %h want %h", ifu_bus.r_valid, 1'b1); else passed++;
    total++; if (ifu_bus.r_data !== 64'h1234) $display("FAIL t1_r_data: got %h want %h", ifu_bus.r_data, 64'h1234); else passed++;
    step(); clear_inputs(); #1;
    total++; if (vr_outs() !== 12'h000) $display("FAIL t1_back_idle: got %h want %h", vr_outs(), 12'h000); else passed++;
  endtask

  task automatic test_lsu_over_ifu();
    step(); ifu_bus.ar_valid = 1; ifu_bus.ar_addr = 64'h1000;
    lsu_bus.ar_valid = 1; lsu_bus.ar_addr = 64'h2000; mem_bus.ar_ready = 1; #1;
    step(); #1;
    total++; if (mem_bus.ar_addr !== 64'h2000) $display("FAIL t2_lsu_addr: got %h want %h", mem_bus.ar_addr, 64'h2000); else passed++;
    total++; if ({lsu_bus.ar_ready, ifu_bus.ar_ready} !== 2'b10) $display("FAIL t2_ar_ready: got %b want %b", {lsu_bus.ar_ready, ifu_bus.ar_ready}, 2'b10); else passed++;
    step(); lsu_bus.ar_valid = 0; lsu_bus.r_ready = 1; mem_bus.r_valid = 1; mem_bus.r_data = 64'hAAAA; #1;
    total++; if (lsu_bus.r_data !== 64'hAAAA) $display("FAIL t2_lsu_r_data: got %h want %h", lsu_bus.r_data, 64'hAAAA); else passed++;
    total++; if ({lsu_bus.r_valid, ifu_bus.r_valid, ifu_bus.ar_ready} !== 3'b100) $display("FAIL t2_lsu_r_flags: got %b want %b", {lsu_bus.r_valid, ifu_bus.r_valid, ifu_bus.ar_ready}, 3'b100); else passed++;
    step(); mem_bus.r_valid = 0; lsu_bus.r_ready = 0; #1;
    total++; if (ifu_bus.ar_ready !== 1'b0) $display("FAIL t2_idle_gap: got %h want %h", ifu_bus.ar_ready, 1'b0); else passed++;
    step(); #1;
    total++; if (ifu_bus.ar_ready !== 1'b1) $display("FAIL t2_ifu_granted: got %h want %h", ifu_bus.ar_ready, 1'b1); else passed++;
    total++; if (mem_bus.ar_addr !== 64'h1000) $display("FAIL t2_ifu_addr: got %h want %h", mem_bus.ar_addr, 64'h1000); else passed++;
    step(); ifu_bus.ar_valid = 0; mem_bus.ar_ready = 0; ifu_bus.r_ready = 1; mem_bus.r_valid = 1; mem_bus.r_data = 64'h5555; #1;
    total++; if (ifu_bus.r_data !== 64'h5555) $display("FAIL t2_ifu_r_data: got %h want %h", ifu_bus.r_data, 64'h5555); else passed++;
    total++; if (lsu_bus.r_valid !== 1'b0) $display("FAIL t2_lsu_r_quiet: got %h want %h", lsu_bus.r_valid, 1'b0); else passed++;
    step(); clear_inputs(); #1;
  endtask

  task automatic test_write_w_first();
    int wr0, b0;
    wr0 = wr_cnt; b0 = b_cnt;
    step(); lsu_bus.aw_valid = 1; lsu_bus.aw_addr = 64'h3000; lsu_bus.w_valid = 1;
    lsu_bus.w_data = 64'hDEAD; lsu_bus.w_strb = 8'h0F; lsu_bus.b_ready = 1; mem_bus.w_ready = 1; #1;
    total++; if ({lsu_bus.aw_ready, lsu_bus.w_ready} !== 2'b00) $display("FAIL t3_idle_ready: got %b want %b", {lsu_bus.aw_ready, lsu_bus.w_ready}, 2'b00); else passed++;
    step(); #1;
    total++; if ({mem_bus.aw_valid, mem_bus.w_valid, lsu_bus.aw_ready, lsu_bus.w_ready} !== 4'b1101) $display("FAIL t3_fwd: got %b want %b", {mem_bus.aw_valid, mem_bus.w_valid, lsu_bus.aw_ready, lsu_bus.w_ready}, 4'b1101); else passed++;
    total++; if (mem_bus.w_data !== 64'hDEAD) $display("FAIL t3_w_data: got %h want %h", mem_bus.w_data, 64'hDEAD); else passed++;
    total++; if (mem_bus.w_strb !== 8'h0F) $display("FAIL t3_w_strb: got %h want %h", mem_bus.w_strb, 8'h0F); else passed++;
    step(); mem_bus.b_valid = 1; #1;
    total++; if ({mem_bus.w_valid, lsu_bus.w_ready} !== 2'b00) $display("FAIL t3_w_stopped: got %b want %b", {mem_bus.w_valid, lsu_bus.w_ready}, 2'b00); else passed++;
    total++; if ({lsu_bus.b_valid, mem_bus.b_ready} !== 2'b00) $display("FAIL t3_b_held_aw: got %b want %b", {lsu_bus.b_valid, mem_bus.b_ready}, 2'b00); else passed++;
    step(); mem_bus.aw_ready = 1; #1;
    total++; if ({mem_bus.aw_valid, lsu_bus.aw_ready, lsu_bus.b_valid} !== 3'b110) $display("FAIL t3_aw_hs: got %b want %b", {mem_bus.aw_valid, lsu_bus.aw_ready, lsu_bus.b_valid}, 3'b110); else passed++;
    total++; if (mem_bus.aw_addr !== 64'h3000) $display("FAIL t3_aw_addr: got %h want %h", mem_bus.aw_addr, 64'h3000); else passed++;
    step(); lsu_bus.aw_valid = 0; lsu_bus.w_valid = 0; mem_bus.aw_ready = 0; #1;
    total++; if ({lsu_bus.b_valid, mem_bus.b_ready, mem_bus.aw_valid} !== 3'b110) $display("FAIL t3_b_fwd: got %b want %b", {lsu_bus.b_valid, mem_bus.b_ready, mem_bus.aw_valid}, 3'b110); else passed++;
    step(); clear_inputs(); #1;
    total++; if (wr_cnt - wr0 !== 1) $display("FAIL t3_write_count: got %0d want %0d", wr_cnt - wr0, 1); else passed++;
    total++; if (b_cnt - b0 !== 1) $display("FAIL t3_b_count: got %0d want %0d", b_cnt - b0, 1); else passed++;
    total++; if (vr_outs() !== 12'h000) $display("FAIL t3_back_idle: got %h want %h", vr_outs(), 12'h000); else passed++;
  endtask

  task automatic test_write_over_fetch();
    step(); lsu_bus.aw_valid = 1; lsu_bus.aw_addr = 64'h4100; lsu_bus.w_valid = 1; lsu_bus.w_data = 64'h11;
    lsu_bus.w_strb = 8'hFF; lsu_bus.b_ready = 1; ifu_bus.ar_valid = 1; ifu_bus.ar_addr = 64'h4000;
    mem_bus.aw_ready = 1; mem_bus.w_ready = 1; mem_bus.ar_ready = 1; #1;
    step(); #1;
    total++; if ({ifu_bus.ar_ready, mem_bus.ar_valid, mem_bus.aw_valid} !== 3'b001) $display("FAIL t4_write_first: got %b want %b", {ifu_bus.ar_ready, mem_bus.ar_valid, mem_bus.aw_valid}, 3'b001); else passed++;
    step(); lsu_bus.aw_valid = 0; lsu_bus.w_valid = 0; mem_bus.b_valid = 1; #1;
    total++; if ({lsu_bus.b_valid, ifu_bus.ar_ready} !== 2'b10) $display("FAIL t4_b_phase: got %b want %b", {lsu_bus.b_valid, ifu_bus.ar_ready}, 2'b10); else passed++;
    step(); mem_bus.b_valid = 0; #1;
    total++; if (ifu_bus.ar_ready !== 1'b0) $display("FAIL t4_idle_gap: got %h want %h", ifu_bus.ar_ready, 1'b0); else passed++;
    step(); #1;
    total++; if (ifu_bus.ar_ready !== 1'b1) $display("FAIL t4_ifu_granted: got %h want %h", ifu_bus.ar_ready, 1'b1); else passed++;
    total++; if (mem_bus.ar_addr !== 64'h4000) $display("FAIL t4_ifu_addr: got %h want %h", mem_bus.ar_addr, 64'h4000); else passed++;
    step(); ifu_bus.ar_valid = 0; mem_bus.ar_ready = 0; ifu_bus.r_ready = 1; mem_bus.r_valid = 1; mem_bus.r_data = 64'h77; #1;
    total++; if (ifu_bus.r_data !== 64'h77) $display("FAIL t4_ifu_r_data: got %h want %h", ifu_bus.r_data, 64'h77); else passed++;
    step(); clear_inputs(); #1;
  endtask

  task automatic test_reset_mid_read();
    step(); ifu_bus.ar_valid = 1; ifu_bus.ar_addr = 64'h8000_0100; mem_bus.ar_ready = 1; #1;
    step(); #1;
    step(); ifu_bus.ar_valid = 0; mem_bus.ar_ready = 0; rst = 1'b1; #1;
    total++; if ({ifu_bus.r_valid, mem_bus.ar_valid} !== 2'b00) $display("FAIL t5_in_if_r: got %b want %b", {ifu_bus.r_valid, mem_bus.ar_valid}, 2'b00); else passed++;
    step(); mem_bus.r_valid = 1; mem_bus.r_data = 64'h99; ifu_bus.r_ready = 1; #1;
    total++; if (vr_outs() !== 12'h000) $display("FAIL t5_after_rst: got %h want %h", vr_outs(), 12'h000); else passed++;
    step(); rst = 1'b0; #1;
    total++; if (ifu_bus.r_valid !== 1'b0) $display("FAIL t5_r_valid_released: got %h want %h", ifu_bus.r_valid, 1'b0); else passed++;
    step(); #1;
    total++; if (vr_outs() !== 12'h000) $display("FAIL t5_stays_idle: got %h want %h", vr_outs(), 12'h000); else passed++;
    step(); clear_inputs(); #1;
  endtask

  task automatic test_lsu_slverr();
    step(); lsu_bus.ar_valid = 1; lsu_bus.ar_addr = 64'h5000; mem_bus.ar_ready = 1; #1;
    step(); #1;
    total++; if (lsu_bus.ar_ready !== 1'b1) $display("FAIL t6_ar_ready: got %h want %h", lsu_bus.ar_ready, 1'b1); else passed++;
    step(); lsu_bus.ar_valid = 0; mem_bus.ar_ready = 0; mem_bus.r_valid = 1; mem_bus.r_data = 64'hBAD;
    mem_bus.r_resp = RESP_SLVERR; #1;
    total++; if (lsu_bus.r_resp !== 2'b10) $display("FAIL t6_resp_stall: got %b want %b", lsu_bus.r_resp, 2'b10); else passed++;
    total++; if ({lsu_bus.r_valid, mem_bus.r_ready, ifu_bus.r_valid} !== 3'b100) $display("FAIL t6_stall_flags: got %b want %b", {lsu_bus.r_valid, mem_bus.r_ready, ifu_bus.r_valid}, 3'b100); else passed++;
    step(); lsu_bus.r_ready = 1; #1;
    total++; if ({lsu_bus.r_valid, mem_bus.r_ready, ifu_bus.r_valid} !== 3'b110) $display("FAIL t6_accept_flags: got %b want %b", {lsu_bus.r_valid, mem_bus.r_ready, ifu_bus.r_valid}, 3'b110); else passed++;
    total++; if (lsu_bus.r_data !== 64'hBAD) $display("FAIL t6_r_data: got %h want %h", lsu_bus.r_data, 64'hBAD); else passed++;
    step(); #1;
    total++; if ({lsu_bus.r_valid, ifu_bus.r_valid, lsu_bus.r_resp} !== 4'b0000) $display("FAIL t6_after: got %b want %b", {lsu_bus.r_valid, ifu_bus.r_valid, lsu_bus.r_resp}, 4'b0000); else passed++;
    step(); clear_inputs(); #1;
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_over_ifu();
    test_write_w_first();
    test_write_over_fetch();
    test_reset_mid_read();
    test_lsu_slverr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
